// File: rtl/prbs8_checker_if.sv
// Bus bundle for prbs8_checker: received-word beat in, lock/error status and display out.
// Optional err_clr line is present only when PRBS_CHK_CLR_EN is defined.
interface prbs8_checker_if;
  // in_valid qualifies in_data for one cycle; there is no ready, the checker accepts every beat.
  logic       in_valid;
  logic [7:0] in_data;
`ifdef PRBS_CHK_CLR_EN
  logic       err_clr;
`endif
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic [6:0] seg_out0;
  logic [6:0] seg_out1;
  logic       dbg_state;
  logic       dbg_pred_ok;

  modport master (
`ifdef PRBS_CHK_CLR_EN
    output err_clr,
`endif
    output in_valid, in_data,
    input  locked, err_pulse, err_cnt, seg_out0, seg_out1, dbg_state, dbg_pred_ok
  );

  modport slave (
`ifdef PRBS_CHK_CLR_EN
    input  err_clr,
`endif
    input  in_valid, in_data,
    output locked, err_pulse, err_cnt, seg_out0, seg_out1, dbg_state, dbg_pred_ok
  );
endinterface

// File: rtl/prbs8_checker.sv
// Receive-side checker for the 8-bit LFSR pattern: hunts for lock, flywheels, counts errors.
// Optional feature macro PRBS_CHK_CLR_EN adds a synchronous err_cnt clear (bus.err_clr).
module prbs8_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic               clk,
  input  logic               rst,
  prbs8_checker_if.slave     bus
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] W_LOCK_CNT = LOCK_CNT[3:0];
  localparam logic [3:0] W_LOSS_CNT = LOSS_CNT[3:0];

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pred, w_pred_nxt;
  logic       r_pred_ok, w_pred_ok_nxt;
  logic [3:0] r_run, w_run_nxt;
  logic       r_err_pulse, w_err_pulse_nxt;
  logic [7:0] r_err_cnt, w_err_cnt_nxt;
  logic [3:0] w_run_inc;

  function automatic logic [7:0] step(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  // Hex digit to segments, gfedcba, active high.
  function automatic logic [6:0] bcd7seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_run_inc = r_run + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_pred      <= 8'h00;
      r_pred_ok   <= 1'b0;
      r_run       <= 4'd0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_pred      <= w_pred_nxt;
      r_pred_ok   <= w_pred_ok_nxt;
      r_run       <= w_run_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pred_nxt      = r_pred;
    w_pred_ok_nxt   = r_pred_ok;
    w_run_nxt       = r_run;
    w_err_pulse_nxt = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          if (bus.in_data == 8'h00) begin
            // All-zero is the LFSR lock-up word: it cannot seed a prediction.
            w_pred_ok_nxt = 1'b0;
            w_run_nxt     = 4'd0;
          end else begin
            w_pred_nxt    = step(bus.in_data);
            w_pred_ok_nxt = 1'b1;
            if (r_pred_ok && (bus.in_data == r_pred)) begin
              if (w_run_inc == W_LOCK_CNT) begin
                w_state_nxt = LOCKED;
                w_run_nxt   = 4'd0;
              end else begin
                w_run_nxt = w_run_inc;
              end
            end else begin
              w_run_nxt = 4'd0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the predictor free-runs so corrupted data cannot reseed it.
          w_pred_nxt = step(r_pred);
          if (bus.in_data == r_pred) begin
            w_run_nxt = 4'd0;
          end else begin
            w_err_pulse_nxt = 1'b1;
            if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
            if (w_run_inc == W_LOSS_CNT) begin
              w_state_nxt   = HUNT;
              w_run_nxt     = 4'd0;
              w_pred_ok_nxt = 1'b0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
`ifdef PRBS_CHK_CLR_EN
    if (bus.err_clr) w_err_cnt_nxt = 8'h00;
`endif
  end

  assign bus.locked      = (r_state == LOCKED);
  assign bus.err_pulse   = r_err_pulse;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.seg_out0    = bcd7seg(r_err_cnt[3:0]);
  assign bus.seg_out1    = bcd7seg(r_err_cnt[7:4]);
  assign bus.dbg_state   = r_state;
  assign bus.dbg_pred_ok = r_pred_ok;

endmodule

// File: tb/tb_prbs8_checker.sv
// Self-checking bench for prbs8_checker: directed scenarios plus random beats against a
// sequence-position reference model.
module tb_prbs8_checker;

  logic clk;
  logic rst;
  prbs8_checker_if bus ();

  prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];
  logic [6:0]  seg_tbl [16];
  int          seq [255];
  int          pos_of [256];

  // reference model: predictor is a position in the 255-long maximal sequence
  bit m_lock, m_have, m_pulse;
  int m_idx, m_run, m_cnt;
  int tx_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int x);
    return (x >> 1) + (($countones(x & 'h1D) % 2) * 128);
  endfunction

  task automatic model_reset();
    m_lock = 0; m_have = 0; m_pulse = 0; m_idx = 0; m_run = 0; m_cnt = 0;
  endtask

  task automatic model_beat(input bit v, input int d, input bit clr);
    m_pulse = 0;
    if (v) begin
      if (!m_lock) begin
        if (d == 0) begin
          m_have = 0;
          m_run  = 0;
        end else begin
          if (m_have && d == seq[m_idx]) m_run++;
          else m_run = 0;
          m_idx  = (pos_of[d] + 1) % 255;
          m_have = 1;
          if (m_run == 4) begin
            m_lock = 1;
            m_run  = 0;
          end
        end
      end else begin
        if (d != seq[m_idx]) begin
          m_pulse = 1;
          if (m_cnt < 255) m_cnt++;
          m_run++;
          if (m_run == 3) begin
            m_lock = 0;
            m_have = 0;
            m_run  = 0;
          end
        end else begin
          m_run = 0;
        end
        m_idx = (m_idx + 1) % 255;
      end
    end
    if (clr) m_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit clr);
    logic [10:0] e;
    bus.in_valid = v;
    bus.in_data  = d;
    rst          = r;
`ifdef PRBS_CHK_CLR_EN
    bus.err_clr  = clr;
`endif
    if (r) model_reset();
    else model_beat(v, int'(d), clr);
    exp_q.push_back({m_have, m_lock, m_pulse, 8'(m_cnt)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("locked",    32'(bus.locked),      32'(e[9]));
    check("err_pulse", 32'(bus.err_pulse),   32'(e[8]));
    check("err_cnt",   32'(bus.err_cnt),     32'(e[7:0]));
    check("pred_ok",   32'(bus.dbg_pred_ok), 32'(e[10]));
    check("seg_out0",  32'(bus.seg_out0),    32'(seg_tbl[e[3:0]]));
    check("seg_out1",  32'(bus.seg_out1),    32'(seg_tbl[e[7:4]]));
  endtask

  task automatic send_good();
    drive(1'b1, 8'(seq[tx_idx]), 1'b0, 1'b0);
    tx_idx = (tx_idx + 1) % 255;
  endtask

  task automatic send_bad();
    logic [7:0] mask;
    mask = 8'($urandom_range(1, 255));
    drive(1'b1, 8'(seq[tx_idx]) ^ mask, 1'b0, 1'b0);
    tx_idx = (tx_idx + 1) % 255;
  endtask

  task automatic idle();
    drive(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 12 && !m_lock; i++) send_good();
    check("lock_up", 32'(bus.locked), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    foreach (pos_of[i]) pos_of[i] = 0;
    seq[0] = 1;
    pos_of[1] = 0;
    for (int i = 1; i < 255; i++) begin
      seq[i] = lfsr_next(seq[i-1]);
      pos_of[seq[i]] = i;
    end
    model_reset();
    tx_idx = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
`ifdef PRBS_CHK_CLR_EN
    bus.err_clr  = 1'b0;
`endif
    rst = 1'b1;

    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_cnt", 32'(bus.err_cnt), 32'd0);

    // lock acquisition with the literal word list
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h80, 1'b0, 1'b0);
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    check("pre_lock", 32'(bus.locked), 32'd0);
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    check("lock_after_0x10", 32'(bus.locked), 32'd1);
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    check("lock_cnt", 32'(bus.err_cnt), 32'd0);
    tx_idx = 6;

    // single error
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    tx_idx = (tx_idx + 1) % 255;
    check("single_pulse", 32'(bus.err_pulse), 32'd1);
    check("single_cnt", 32'(bus.err_cnt), 32'd1);
    for (int i = 0; i < 6; i++) send_good();
    check("single_stay_lock", 32'(bus.locked), 32'd1);
    check("single_cnt_hold", 32'(bus.err_cnt), 32'd1);

    // loss of lock and re-acquisition
    for (int i = 0; i < 3; i++) send_bad();
    check("loss_unlocked", 32'(bus.locked), 32'd0);
    check("loss_cnt", 32'(bus.err_cnt), 32'd4);
    lock_up();

    // valid gaps inside a locked stream
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      else send_good();
    end
    check("gaps_cnt", 32'(bus.err_cnt), 32'd4);

    // reset mid-lock with a beat in flight
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    check("midrst_locked", 32'(bus.locked), 32'd0);
    check("midrst_cnt", 32'(bus.err_cnt), 32'd0);

    // zero words in HUNT
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h00, 1'b0, 1'b0);
    check("zero_pred_ok", 32'(bus.dbg_pred_ok), 32'd0);
    check("zero_locked", 32'(bus.locked), 32'd0);

    // saturation: 300 mismatches in locked bursts
    for (int k = 0; k < 300; k++) begin
      if (!m_lock) lock_up();
      send_bad();
    end
    check("sat_cnt", 32'(bus.err_cnt), 32'hFF);
    check("sat_seg0_F", 32'(bus.seg_out0), 32'h71);
    check("sat_seg1_F", 32'(bus.seg_out1), 32'h71);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // random mix
    for (int i = 0; i < 2000; i++) begin
      int r;
      bit clr;
      r = $urandom_range(0, 99);
      clr = 1'b0;
`ifdef PRBS_CHK_CLR_EN
      clr = ($urandom_range(0, 49) == 0);
`endif
      if ($urandom_range(0, 399) == 0) begin
        drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      end else if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 8'($urandom), 1'b0, clr);
      end else if (r < 8) begin
        drive(1'b1, 8'(seq[tx_idx]) ^ 8'($urandom_range(1, 255)), 1'b0, clr);
        tx_idx = (tx_idx + 1) % 255;
      end else if (r < 10) begin
        drive(1'b1, 8'h00, 1'b0, clr);
        tx_idx = (tx_idx + 1) % 255;
      end else begin
        drive(1'b1, 8'(seq[tx_idx]), 1'b0, clr);
        tx_idx = (tx_idx + 1) % 255;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
